// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the core dispatcher: FSM state encoding,
// default PC width and the round-robin picker used by the arbiter.
package dispatch_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int MAX_CORES = 16;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_RUN   = 2'd1,
    DS_DRAIN = 2'd2
  } dispatch_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // Rotate the request vector so ptr sits at bit 0, priority-encode the
  // lowest set bit, then map the result back to an absolute core index.
  // Only the low n bits of req are considered.
  function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0] req,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (req[j[3:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dispatch_task_fifo.sv
// Synchronous task FIFO holding pending start PCs. dout always shows the
// head entry; push into a full FIFO and pop from an empty one are ignored.
module dispatch_task_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_dispatcher.sv
// Hands queued task PCs to idle shader cores with round-robin fairness and
// sequences frames IDLE -> RUN -> DRAIN -> IDLE. Optional statistics
// counters are built when CORE_DISPATCH_STATS_EN is defined.
//
// Handshakes: a task is taken on any edge where task_valid & task_ready.
// A core is offered a PC by a one-cycle set_pc pulse with new_pc valid in
// the same cycle; the core signals it is free again by raising request_new_pc.
module core_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int PC_W       = PC_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 drain,
  input  logic                 task_valid,
  input  logic [PC_W-1:0]      task_pc,
  output logic                 task_ready,
  input  logic [NUM_CORES-1:0] request_new_pc,
  output logic [NUM_CORES-1:0] set_pc,
  output logic [PC_W-1:0]      new_pc,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
`ifdef CORE_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_dispatched,
  output logic [31:0]          stat_starved
`endif
);

  dispatch_state_t        state;
  logic [3:0]             rr_ptr;
  logic [NUM_CORES-1:0]   elig;
  logic [MAX_CORES-1:0]   elig_ext;
  rr_pick_t               pick;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PC_W-1:0]        fifo_head;
  logic                   push;

  assign task_ready = (state == DS_RUN) & ~fifo_full;
  assign push       = task_valid & task_ready;
  assign busy       = (state != DS_IDLE);
  assign dbg_state  = state;

  // A core still showing its request in the cycle after a grant is masked
  // so it cannot be handed a second task before it has started the first.
  assign elig = request_new_pc & ~set_pc & {NUM_CORES{~fifo_empty}}
              & {NUM_CORES{state != DS_IDLE}};

  always_comb begin
    elig_ext                = '0;
    elig_ext[NUM_CORES-1:0] = elig;
    pick                    = rr_pick(elig_ext, rr_ptr, NUM_CORES);
  end

  dispatch_task_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pick.valid),
    .din   (task_pc),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DS_IDLE;
      set_pc <= '0;
      new_pc <= '0;
      rr_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DS_IDLE:  if (start) state <= DS_RUN;
        DS_RUN:   if (drain) state <= DS_DRAIN;
        DS_DRAIN: begin
          if (fifo_empty && (set_pc == '0) && (&request_new_pc)) begin
            state <= DS_IDLE;
            done  <= 1'b1;
          end
        end
        default:  state <= DS_IDLE;
      endcase

      if (pick.valid) begin
        set_pc <= {{(NUM_CORES-1){1'b0}}, 1'b1} << pick.idx;
        new_pc <= fifo_head;
        if (pick.idx == 4'(NUM_CORES - 1)) rr_ptr <= '0;
        else                               rr_ptr <= pick.idx + 4'd1;
      end else begin
        set_pc <= '0;
      end
    end
  end

`ifdef CORE_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      stat_dispatched <= '0;
      stat_starved    <= '0;
    end else begin
      if (pick.valid && (stat_dispatched != '1))
        stat_dispatched <= stat_dispatched + 32'd1;
      if ((state != DS_IDLE) && fifo_empty && (|request_new_pc) && (stat_starved != '1))
        stat_starved <= stat_starved + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher: hand-computed grant sequences, FIFO
// full/flush behaviour, drain/done sequencing and optional stats counters.
module tb_core_dispatcher;
  import dispatch_pkg::*;

  localparam int N  = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          drain;
  logic          task_valid;
  logic [PW-1:0] task_pc;
  logic          task_ready;
  logic [N-1:0]  request_new_pc;
  logic [N-1:0]  set_pc;
  logic [PW-1:0] new_pc;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;
`ifdef CORE_DISPATCH_STATS_EN
  logic [31:0]   stat_dispatched;
  logic [31:0]   stat_starved;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  core_dispatcher #(.NUM_CORES(N), .PC_W(PW), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .drain          (drain),
    .task_valid     (task_valid),
    .task_pc        (task_pc),
    .task_ready     (task_ready),
    .request_new_pc (request_new_pc),
    .set_pc         (set_pc),
    .new_pc         (new_pc),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
`ifdef CORE_DISPATCH_STATS_EN
    ,
    .stat_dispatched(stat_dispatched),
    .stat_starved   (stat_starved)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; drain = 1'b0;
    task_valid = 1'b0; task_pc = '0; request_new_pc = '0;
    tick(); tick();
    check_eq("rst_set_pc", 32'(set_pc), 32'h0);
    check_eq("rst_new_pc", 32'(new_pc), 32'h0);
    check_eq("rst_ready", 32'(task_ready), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    request_new_pc = 4'hF;
    tick();
    check_eq("idle_no_grant", 32'(set_pc), 32'h0);

    // 1: three tasks, all cores requesting
    start = 1'b1; tick(); start = 1'b0;
    check_eq("t1_state", 32'(dbg_state), 32'(DS_RUN));
    check_eq("t1_busy", 32'(busy), 32'h1);
    check_eq("t1_ready", 32'(task_ready), 32'h1);
    task_valid = 1'b1; task_pc = 16'h0010; tick();
    check_eq("t1_no_bypass", 32'(set_pc), 32'h0);
    task_pc = 16'h0020; tick();
    check_eq("t1_g0_set", 32'(set_pc), 32'h1);
    check_eq("t1_g0_pc", 32'(new_pc), 32'h10);
    task_pc = 16'h0030; tick();
    task_valid = 1'b0;
    check_eq("t1_g1_set", 32'(set_pc), 32'h2);
    check_eq("t1_g1_pc", 32'(new_pc), 32'h20);
    tick();
    check_eq("t1_g2_set", 32'(set_pc), 32'h4);
    check_eq("t1_g2_pc", 32'(new_pc), 32'h30);
    tick();
    check_eq("t1_empty_set", 32'(set_pc), 32'h0);
    check_eq("t1_hold_pc", 32'(new_pc), 32'h30);

    // 2: core1 alone, two queued tasks
    request_new_pc = 4'h0;
    task_valid = 1'b1; task_pc = 16'h00A1; tick();
    task_pc = 16'h00A2; tick();
    task_valid = 1'b0;
    request_new_pc = 4'b0010; tick();
    check_eq("t2_g_set", 32'(set_pc), 32'h2);
    check_eq("t2_g_pc", 32'(new_pc), 32'hA1);
    tick();
    check_eq("t2_masked", 32'(set_pc), 32'h0);
    request_new_pc = 4'h0; tick();
    check_eq("t2_wait_a", 32'(set_pc), 32'h0);
    tick();
    check_eq("t2_wait_b", 32'(set_pc), 32'h0);
    request_new_pc = 4'b0010; tick();
    check_eq("t2_g2_set", 32'(set_pc), 32'h2);
    check_eq("t2_g2_pc", 32'(new_pc), 32'hA2);
    request_new_pc = 4'h0; tick();
    check_eq("t2_idle", 32'(set_pc), 32'h0);

    // 3: fill to full, ninth task waits for a pop
    for (int k = 0; k < 8; k++) begin
      task_valid = 1'b1; task_pc = 16'(16'h0100 + k);
      check_eq("t3_ready_fill", 32'(task_ready), 32'h1);
      tick();
    end
    check_eq("t3_full", 32'(task_ready), 32'h0);
    task_pc = 16'h0108; tick();
    check_eq("t3_full_hold", 32'(task_ready), 32'h0);
    request_new_pc = 4'b0001; tick();
    check_eq("t3_g_set", 32'(set_pc), 32'h1);
    check_eq("t3_g_pc", 32'(new_pc), 32'h100);
    check_eq("t3_ready_again", 32'(task_ready), 32'h1);
    request_new_pc = 4'h0; tick();
    task_valid = 1'b0;
    check_eq("t3_full_again", 32'(task_ready), 32'h0);
    request_new_pc = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t3_drain_set", 32'(set_pc), 32'h1 << ((1 + i) % 4));
      check_eq("t3_drain_pc", 32'(new_pc), 32'h101 + 32'(i));
    end
    tick();
    check_eq("t3_empty", 32'(set_pc), 32'h0);

    // 4: drain with two queued tasks
    request_new_pc = 4'h0;
    task_valid = 1'b1; task_pc = 16'h00B0; tick();
    task_pc = 16'h00B1; tick();
    task_valid = 1'b0;
    drain = 1'b1; request_new_pc = 4'hF; tick(); drain = 1'b0;
    check_eq("t4_state", 32'(dbg_state), 32'(DS_DRAIN));
    check_eq("t4_ready", 32'(task_ready), 32'h0);
    check_eq("t4_g0_set", 32'(set_pc), 32'h2);
    check_eq("t4_g0_pc", 32'(new_pc), 32'hB0);
    request_new_pc = 4'b1101; tick();
    check_eq("t4_g1_set", 32'(set_pc), 32'h4);
    check_eq("t4_g1_pc", 32'(new_pc), 32'hB1);
    request_new_pc = 4'b1001; tick();
    check_eq("t4_done_a", 32'(done), 32'h0);
    tick();
    check_eq("t4_done_b", 32'(done), 32'h0);
    check_eq("t4_busy_b", 32'(busy), 32'h1);
    request_new_pc = 4'b1011; tick();
    check_eq("t4_done_c", 32'(done), 32'h0);
    request_new_pc = 4'hF; tick();
    check_eq("t4_done", 32'(done), 32'h1);
    check_eq("t4_busy", 32'(busy), 32'h0);
    drain = 1'b1; tick(); drain = 1'b0;
    check_eq("t4_done_pulse", 32'(done), 32'h0);
    check_eq("t4_idle_drain", 32'(dbg_state), 32'(DS_IDLE));

    // 5: reset with queued tasks and a pending grant
    start = 1'b1; tick(); start = 1'b0;
    request_new_pc = 4'h0;
    for (int k = 0; k < 3; k++) begin
      task_valid = 1'b1; task_pc = 16'(16'h00C0 + k); tick();
    end
    task_valid = 1'b0;
    request_new_pc = 4'b0001; rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_set_pc", 32'(set_pc), 32'h0);
    check_eq("t5_busy", 32'(busy), 32'h0);
    check_eq("t5_ready", 32'(task_ready), 32'h0);
    start = 1'b1; drain = 1'b1; request_new_pc = 4'hF; tick();
    start = 1'b0; drain = 1'b0;
    check_eq("t5_start_drain", 32'(dbg_state), 32'(DS_RUN));
    check_eq("t5_ready2", 32'(task_ready), 32'h1);
    tick();
    check_eq("t5_flushed", 32'(set_pc), 32'h0);
    task_valid = 1'b1; task_pc = 16'h00D0; tick();
    task_valid = 1'b0;
    check_eq("t5_nobypass", 32'(set_pc), 32'h0);
    tick();
    check_eq("t5_g_set", 32'(set_pc), 32'h1);
    check_eq("t5_g_pc", 32'(new_pc), 32'hD0);

`ifdef CORE_DISPATCH_STATS_EN
    // 6: statistics counters
    rst = 1'b1; request_new_pc = 4'h0; tick(); rst = 1'b0;
    check_eq("t6_rst_disp", stat_dispatched, 32'd0);
    check_eq("t6_rst_starv", stat_starved, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      task_valid = 1'b1; task_pc = 16'(16'h00E0 + k); tick();
    end
    task_valid = 1'b0;
    request_new_pc = 4'hF;
    for (int k = 0; k < 5; k++) tick();
    request_new_pc = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    request_new_pc = 4'h0; tick();
    check_eq("t6_dispatched", stat_dispatched, 32'd5);
    check_eq("t6_starved", stat_starved, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
